// File: rtl/bk_pkg.sv
// Shared types and helpers for the pipelined Brent-Kung adder/subtractor.
package bk_pkg;

    // One (propagate, generate) pair; p sits in the upper bit.
    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Number of prefix-tree levels for a given operand width.
    function automatic int levels(input int width);
        return clog2(width);
    endfunction

    // Black cell: merge a higher group with the adjacent lower group.
    function automatic pg_t black_cell(input pg_t hi, input pg_t lo);
        pg_t res;
        res.p = hi.p & lo.p;
        res.g = hi.g | (hi.p & lo.g);
        return res;
    endfunction

    // Grey cell: only the group generate is needed (carry formation).
    function automatic logic grey_cell(input pg_t hi, input logic lo_g);
        return hi.g | (hi.p & lo_g);
    endfunction

endpackage

// File: rtl/bk_adder_pipe_if.sv
// Operand and result handshake bundle of the pipelined adder.
interface bk_adder_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/bk_prefix_tree.sv
// Combinational Brent-Kung prefix tree, split into up-sweep and down-sweep
// halves so a pipeline register can sit between them (mid_* ports).
module bk_prefix_tree
    import bk_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] up_p,
    output logic [WIDTH-1:0] up_g,
    input  logic [WIDTH-1:0] mid_p,
    input  logic [WIDTH-1:0] mid_g,
    output logic [WIDTH-1:0] grp_p,
    output logic [WIDTH-1:0] grp_g
);
    localparam int LEVELS = levels(WIDTH);

    logic [LEVELS:0][WIDTH-1:0] us_p;
    logic [LEVELS:0][WIDTH-1:0] us_g;
    logic [LEVELS:1][WIDTH-1:0] ds_p;
    logic [LEVELS:1][WIDTH-1:0] ds_g;

    assign us_p[0] = p;
    assign us_g[0] = g;

    // Up-sweep: at level l, bit i with (i+1) a multiple of 2^l absorbs the
    // group ending 2^(l-1) below it.
    for (genvar l = 1; l <= LEVELS; l++) begin : g_up
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i + 1) % (1 << l)) == 0) begin : g_black
                pg_t res;
                assign res = black_cell(pg_t'({us_p[l-1][i], us_g[l-1][i]}),
                                        pg_t'({us_p[l-1][i-(1<<(l-1))], us_g[l-1][i-(1<<(l-1))]}));
                assign us_p[l][i] = res.p;
                assign us_g[l][i] = res.g;
            end else begin : g_pass
                assign us_p[l][i] = us_p[l-1][i];
                assign us_g[l][i] = us_g[l-1][i];
            end
        end
    end

    assign up_p = us_p[LEVELS];
    assign up_g = us_g[LEVELS];

    assign ds_p[LEVELS] = mid_p;
    assign ds_g[LEVELS] = mid_g;

    // Down-sweep: fill the remaining prefixes, widest span first, so each
    // bit joins a neighbour that already holds its complete prefix.
    for (genvar l = LEVELS - 1; l >= 1; l--) begin : g_dn
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((((i + 1) % (1 << l)) == (1 << (l - 1))) && (i >= (1 << l))) begin : g_black
                pg_t res;
                assign res = black_cell(pg_t'({ds_p[l+1][i], ds_g[l+1][i]}),
                                        pg_t'({ds_p[l+1][i-(1<<(l-1))], ds_g[l+1][i-(1<<(l-1))]}));
                assign ds_p[l][i] = res.p;
                assign ds_g[l][i] = res.g;
            end else begin : g_pass
                assign ds_p[l][i] = ds_p[l+1][i];
                assign ds_g[l][i] = ds_g[l+1][i];
            end
        end
    end

    assign grp_p = ds_p[1];
    assign grp_g = ds_g[1];
endmodule

// File: rtl/bk_adder_pipe.sv
// Three-stage pipelined Brent-Kung adder/subtractor with valid/ready on both
// sides; S1 = bitwise p/g, S2 = up-sweep, S3 = down-sweep, carries and sum.
module bk_adder_pipe
    import bk_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    bk_adder_pipe_if.slave bus
);
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic             s1_load, s2_load, s3_load;
    logic             v1, v2, v3;
    logic [WIDTH-1:0] s1_p, s1_g;
    logic             s1_c0;
    logic [WIDTH-1:0] up_p, up_g;
    logic [WIDTH-1:0] s2_up_p, s2_up_g, s2_p;
    logic             s2_c0;
    logic [WIDTH-1:0] grp_p, grp_g;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s3_sum;
    logic             s3_cout, s3_ovf;

    // Subtraction is A + ~B + ~borrow_in.
    assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign c0    = bus.in_sub ? ~bus.in_cin : bus.in_cin;

    // Ready chain runs combinationally from out_ready back to in_ready.
    assign s3_load      = !v3 || bus.out_ready;
    assign s2_load      = !v2 || s3_load;
    assign s1_load      = !v1 || s2_load;
    assign bus.in_ready = !rst && s1_load;

    bk_prefix_tree #(.WIDTH(WIDTH)) u_tree (
        .p     (s1_p),
        .g     (s1_g),
        .up_p  (up_p),
        .up_g  (up_g),
        .mid_p (s2_up_p),
        .mid_g (s2_up_g),
        .grp_p (grp_p),
        .grp_g (grp_g)
    );

    // Carry into bit i is the prefix [i-1:0] merged with the carry-in.
    assign carry[0] = s2_c0;
    for (genvar i = 1; i <= WIDTH; i++) begin : g_carry
        assign carry[i] = grey_cell(pg_t'({grp_p[i-1], grp_g[i-1]}), s2_c0);
    end

    // S1: capture per-bit propagate/generate of the conditioned operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            s1_p  <= '0;
            s1_g  <= '0;
            s1_c0 <= 1'b0;
        end else begin
            if (s1_load) v1 <= bus.in_valid;
            if (s1_load && bus.in_valid) begin
                s1_p  <= bus.in_a ^ b_eff;
                s1_g  <= bus.in_a & b_eff;
                s1_c0 <= c0;
            end
        end
    end

    // S2: capture the up-sweep result alongside the raw propagates.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2      <= 1'b0;
            s2_up_p <= '0;
            s2_up_g <= '0;
            s2_p    <= '0;
            s2_c0   <= 1'b0;
        end else begin
            if (s2_load) v2 <= v1;
            if (s2_load && v1) begin
                s2_up_p <= up_p;
                s2_up_g <= up_g;
                s2_p    <= s1_p;
                s2_c0   <= s1_c0;
            end
        end
    end

    // S3: form sum, carry-out and overflow; data holds while invalid or stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3      <= 1'b0;
            s3_sum  <= '0;
            s3_cout <= 1'b0;
            s3_ovf  <= 1'b0;
        end else begin
            if (s3_load) v3 <= v2;
            if (s3_load && v2) begin
                s3_sum  <= s2_p ^ carry[WIDTH-1:0];
                s3_cout <= carry[WIDTH];
                s3_ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
            end
        end
    end

    assign bus.out_valid = v3;
    assign bus.out_sum   = s3_sum;
    assign bus.out_cout  = s3_cout;
    assign bus.out_ovf   = s3_ovf;
endmodule

// File: tb/tb_bk_adder_pipe.sv
// Bench for bk_adder_pipe: directed WIDTH=8 vectors, backpressure and
// mid-flight reset sequences, plus random streams at WIDTH=4/16/32/64.
module tb_bk_adder_pipe;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    localparam int NUM_VECS   = 10;
    localparam int RAND_BEATS = 2000;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    bk_adder_pipe_if #(.WIDTH(8)) bus8 ();

    bk_adder_pipe #(.WIDTH(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and log a line on mismatch.
    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Arithmetic reference: returns {ovf, cout, sum} for width w.
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [63:0] mask, beff, am, sum;
        logic [64:0] full;
        logic        c0, cout, ovf;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        beff = sub ? (~b & mask) : (b & mask);
        c0   = sub ? ~cin : cin;
        full = {1'b0, am} + {1'b0, beff} + {64'd0, c0};
        sum  = full[63:0] & mask;
        cout = full[w];
        ovf  = (am[w-1] == beff[w-1]) && (sum[w-1] != am[w-1]);
        return {ovf, cout, sum};
    endfunction

    // Drive one beat and wait (bounded) for its result.
    task automatic apply_stimulus(input vec_t v, output int lat);
        @(negedge clk);
        bus8.in_valid = 1'b1;
        bus8.in_a     = v.a;
        bus8.in_b     = v.b;
        bus8.in_cin   = v.cin;
        bus8.in_sub   = v.sub;
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_output(input vec_t v, input int lat, input string tag);
        check({tag, "_latency"}, 64'(lat), 64'(3));
        check({tag, "_sum"}, 64'(bus8.out_sum), 64'(v.sum));
        check({tag, "_cout"}, 64'(bus8.out_cout), 64'(v.cout));
        check({tag, "_ovf"}, 64'(bus8.out_ovf), 64'(v.ovf));
    endtask

    // Random streams at other widths, each with its own reset and scoreboard.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rand
        localparam int W = (gi == 0) ? 4 : (8 << gi);
        logic        rst_l;
        bit          done;
        logic [65:0] exp_q [$];

        bk_adder_pipe_if #(.WIDTH(W)) rbus ();

        bk_adder_pipe #(.WIDTH(W)) u_dut (
            .clk (clk),
            .rst (rst_l),
            .bus (rbus)
        );

        initial begin
            logic [63:0] r_a, r_b;
            logic [65:0] exp;
            int          sent, got, cycles;
            bit          took;
            done = 1'b0;
            rst_l = 1'b1;
            rbus.in_valid = 1'b0; rbus.in_a = '0; rbus.in_b = '0;
            rbus.in_cin = 1'b0; rbus.in_sub = 1'b0; rbus.out_ready = 1'b0;
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst_l = 1'b0;
            sent = 0; got = 0; cycles = 0; took = 1'b0;
            while (got < RAND_BEATS && cycles < 20000) begin
                @(negedge clk);
                cycles++;
                rbus.out_ready = ($urandom_range(0, 3) != 0);
                if (!rbus.in_valid || took) begin
                    if (sent < RAND_BEATS && $urandom_range(0, 4) != 0) begin
                        r_a = {$urandom, $urandom};
                        r_b = {$urandom, $urandom};
                        rbus.in_valid = 1'b1;
                        rbus.in_a     = r_a[W-1:0];
                        rbus.in_b     = r_b[W-1:0];
                        rbus.in_cin   = 1'($urandom_range(0, 1));
                        rbus.in_sub   = 1'($urandom_range(0, 1));
                    end else begin
                        rbus.in_valid = 1'b0;
                    end
                end
                #1;
                took = rbus.in_valid && rbus.in_ready;
                if (took) begin
                    exp_q.push_back(model(W, 64'(rbus.in_a), 64'(rbus.in_b), rbus.in_cin, rbus.in_sub));
                    sent++;
                end
                if (rbus.out_valid && rbus.out_ready) begin
                    check($sformatf("rand%0d_pending", W), 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        check($sformatf("rand%0d_sum", W), 64'(rbus.out_sum), exp[63:0]);
                        check($sformatf("rand%0d_cout", W), 64'(rbus.out_cout), 64'(exp[64]));
                        check($sformatf("rand%0d_ovf", W), 64'(rbus.out_ovf), 64'(exp[65]));
                    end
                    got++;
                end
            end
            check($sformatf("rand%0d_beats", W), 64'(got), 64'(RAND_BEATS));
            done = 1'b1;
        end
    end

    // Global time limit so a wedged run still ends.
    initial begin
        #(800000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed WIDTH=8 sequence.
    initial begin
        vec_t        vecs [NUM_VECS];
        vec_t        post_vec;
        logic [65:0] bp_exp [10];
        logic [7:0]  bp_a [10];
        logic [7:0]  bp_b [10];
        int          lat, sent, got, stale;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
        post_vec = '{8'h21, 8'h12, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0};

        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0;
        bus8.in_cin = 1'b0; bus8.in_sub = 1'b0; bus8.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 64'(bus8.in_ready), 64'(0));
        check("reset_out_valid", 64'(bus8.out_valid), 64'(0));
        check("reset_out_sum", 64'(bus8.out_sum), 64'(0));
        check("reset_out_cout", 64'(bus8.out_cout), 64'(0));
        check("reset_out_ovf", 64'(bus8.out_ovf), 64'(0));
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", 64'(bus8.in_ready), 64'(1));
        bus8.out_ready = 1'b1;

        for (int i = 0; i < NUM_VECS; i++) begin
            apply_stimulus(vecs[i], lat);
            check_output(vecs[i], lat, $sformatf("vec%0d", i));
        end

        // Backpressure: 10 beats back-to-back, consumer stalls cycles 3..7.
        for (int k = 0; k < 10; k++) begin
            bp_a[k]   = 8'(k * 37 + 5);
            bp_b[k]   = 8'(k * 11 + 200);
            bp_exp[k] = model(8, 64'(bp_a[k]), 64'(bp_b[k]), k[1], k[0]);
        end
        sent = 0;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            bus8.out_ready = !(c >= 3 && c <= 7);
            if (sent < 10) begin
                bus8.in_valid = 1'b1;
                bus8.in_a     = bp_a[sent];
                bus8.in_b     = bp_b[sent];
                bus8.in_cin   = sent[1];
                bus8.in_sub   = sent[0];
            end else begin
                bus8.in_valid = 1'b0;
            end
            #1;
            if (c >= 3 && c <= 7) begin
                check("bp_stall_in_ready", 64'(bus8.in_ready), 64'(0));
                check("bp_hold_valid", 64'(bus8.out_valid), 64'(1));
                check("bp_hold_sum", 64'(bus8.out_sum), bp_exp[0][63:0]);
            end
            if (c >= 8 && c <= 14) check("bp_resume_in_ready", 64'(bus8.in_ready), 64'(1));
            if (bus8.in_valid && bus8.in_ready) sent++;
            if (bus8.out_valid && bus8.out_ready && got < 10) begin
                check("bp_out_cycle", 64'(c), 64'(8 + got));
                check("bp_sum", 64'(bus8.out_sum), bp_exp[got][63:0]);
                check("bp_cout", 64'(bus8.out_cout), 64'(bp_exp[got][64]));
                check("bp_ovf", 64'(bus8.out_ovf), 64'(bp_exp[got][65]));
                got++;
            end
        end
        check("bp_sent", 64'(sent), 64'(10));
        check("bp_got", 64'(got), 64'(10));

        // Reset with three beats in flight.
        bus8.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus8.in_valid = 1'b1;
            bus8.in_a     = 8'h40 + 8'(k);
            bus8.in_b     = 8'h01;
            bus8.in_cin   = 1'b0;
            bus8.in_sub   = 1'b0;
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_full", 64'(bus8.out_valid), 64'(1));
        check("rst_mid_in_ready", 64'(bus8.in_ready), 64'(0));
        @(negedge clk);
        check("rst_mid_out_valid", 64'(bus8.out_valid), 64'(0));
        check("rst_mid_out_sum", 64'(bus8.out_sum), 64'(0));
        check("rst_mid_out_cout", 64'(bus8.out_cout), 64'(0));
        rst = 1'b0;
        bus8.out_ready = 1'b1;
        #1;
        check("rst_mid_release_ready", 64'(bus8.in_ready), 64'(1));
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (bus8.out_valid) stale++;
        end
        check("rst_mid_stale_beats", 64'(stale), 64'(0));
        apply_stimulus(post_vec, lat);
        check_output(post_vec, lat, "post_rst");

        wait (g_rand[0].done && g_rand[1].done && g_rand[2].done && g_rand[3].done);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
